// File: rtl/wave_capture.sv
// Writer side of the two-bank 512x8 waveform RAM: arms on a positive-going zero
// crossing, writes 256 samples to the hidden bank, then flips banks when the display is idle.
// Optional forced trigger after AUTO_TIMEOUT quiet samples: define AUTO_TRIGGER_EN.
module wave_capture #(
  parameter int SAMPLE_W     = 16,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index,
  output logic [1:0]          state_dbg
);

  // Handshake: new_sample_ready is a one-cycle strobe with no back-pressure; every
  // strobe is consumed in the cycle it appears, and RAM writes are fire-and-forget pulses.
  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  count_q;
  logic [7:0]  count_d;
  logic        prev_sign_q;
  logic        read_index_q;
  logic        write_enable_q;
  logic [8:0]  write_address_q;
  logic [7:0]  write_sample_q;

  logic        sample_sign;
  logic [7:0]  sample_byte;
  logic        zero_cross;
  logic        timeout_hit;
  logic        start_capture;

  generate
    if (SAMPLE_W < 8 || AUTO_TIMEOUT < 1) begin : g_bad_cfg
      $error("wave_capture: SAMPLE_W must be >= 8 and AUTO_TIMEOUT >= 1");
    end
    if (SAMPLE_W > 8) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
    end
  endgenerate

  // Offset-binary conversion: flipping the sign bit maps signed -128..127 onto 0..255.
  assign sample_sign   = new_sample_in[SAMPLE_W-1];
  assign sample_byte   = new_sample_in[SAMPLE_W-1 -: 8] ^ 8'h80;
  assign zero_cross    = new_sample_ready && prev_sign_q && !sample_sign;
  assign start_capture = zero_cross || (new_sample_ready && timeout_hit);
  assign count_d       = count_q + 8'd1;

`ifdef AUTO_TRIGGER_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] timeout_q;

  assign timeout_hit = (timeout_q == TO_W'(AUTO_TIMEOUT - 1));

  // Held at zero outside ARMED so each arming period starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= '0;
    end else if (state_q != ARMED || start_capture) begin
      timeout_q <= '0;
    end else if (new_sample_ready) begin
      timeout_q <= timeout_q + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ARMED;
      count_q         <= 8'd0;
      prev_sign_q     <= 1'b0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= 9'd0;
      write_sample_q  <= 8'd0;
    end else begin
      write_enable_q <= 1'b0;
      if (new_sample_ready) begin
        prev_sign_q <= sample_sign;
      end
      unique case (state_q)
        ARMED: begin
          if (start_capture) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, 8'd0};
            write_sample_q  <= sample_byte;
            count_q         <= 8'd1;
            state_q         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, count_q};
            write_sample_q  <= sample_byte;
            count_q         <= count_d;
            if (count_q == 8'hFF) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // A sample arriving with idle is swallowed here; only prev_sign sees it.
          if (wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state_q      <= ARMED;
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign write_address = write_address_q;
  assign write_enable  = write_enable_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: trigger detection, full captures into both banks,
// bank flip timing, same-cycle sample/idle, mid-capture reset and the auto trigger option.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_ARMED  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(16), .AUTO_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .state_dbg         (state_dbg)
  );

  // Strobe one sample; returns on the negedge after the accepting posedge.
  task automatic send_sample(input logic [15:0] v);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = v;
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = 16'h0; wave_display_idle = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b want=0", write_enable); end
    checks++; if (write_address !== 9'h000) begin failures++; $display("FAIL reset_addr got=%h want=000", write_address); end
    checks++; if (write_sample !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", write_sample); end
    checks++; if (read_index !== 1'b0) begin failures++; $display("FAIL reset_ri got=%0b want=0", read_index); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_no_trigger();
    send_sample(16'h0100);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL notrig_we1 got=%0b want=0", write_enable); end
    send_sample(16'h0200);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL notrig_we2 got=%0b want=0", write_enable); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL notrig_state got=%0d want=0", state_dbg); end
    checks++; if (read_index !== 1'b0) begin failures++; $display("FAIL notrig_ri got=%0b want=0", read_index); end
  endtask

  task automatic test_trigger();
    send_sample(16'hFFFB);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL trig_neg_we got=%0b want=0", write_enable); end
    send_sample(16'h0003);
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL trig_we got=%0b want=1", write_enable); end
    checks++; if (write_address !== 9'h100) begin failures++; $display("FAIL trig_addr got=%h want=100", write_address); end
    checks++; if (write_sample !== 8'h80) begin failures++; $display("FAIL trig_data got=%h want=80", write_sample); end
    checks++; if (state_dbg !== S_ACTIVE) begin failures++; $display("FAIL trig_state got=%0d want=1", state_dbg); end
    @(negedge clk);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL trig_pulse got=%0b want=0", write_enable); end
  endtask

  task automatic test_capture_fill();
    logic [8:0] exp_addr;
    logic [7:0] exp_data;
    for (int i = 1; i < 256; i++) begin
      send_sample(16'(i << 8));
      exp_addr = 9'(256 + i);
      exp_data = 8'(i) ^ 8'h80;
      checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL fill_we[%0d] got=%0b want=1", i, write_enable); end
      checks++; if (write_address !== exp_addr) begin failures++; $display("FAIL fill_addr[%0d] got=%h want=%h", i, write_address, exp_addr); end
      checks++; if (write_sample !== exp_data) begin failures++; $display("FAIL fill_data[%0d] got=%h want=%h", i, write_sample, exp_data); end
    end
    @(negedge clk);
    checks++; if (state_dbg !== S_WAIT) begin failures++; $display("FAIL fill_state got=%0d want=2", state_dbg); end
    send_sample(16'h0100);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL fill_extra_we got=%0b want=0", write_enable); end
    checks++; if (read_index !== 1'b0) begin failures++; $display("FAIL fill_ri_hold got=%0b want=0", read_index); end
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    checks++; if (read_index !== 1'b1) begin failures++; $display("FAIL fill_flip got=%0b want=1", read_index); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL fill_rearm got=%0d want=0", state_dbg); end
  endtask

  // Idle held high for the whole capture: the flip must land on the first WAIT cycle.
  task automatic test_second_capture();
    logic [8:0] exp_addr;
    wave_display_idle = 1'b1;
    send_sample(16'h8000);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL cap2_neg_we got=%0b want=0", write_enable); end
    send_sample(16'h0000);
    checks++; if (write_address !== 9'h000 || write_enable !== 1'b1) begin failures++; $display("FAIL cap2_first got=%h/%0b want=000/1", write_address, write_enable); end
    for (int i = 1; i < 256; i++) begin
      send_sample(16'(i << 8));
      exp_addr = 9'(i);
      checks++; if (write_address !== exp_addr || write_enable !== 1'b1) begin failures++; $display("FAIL cap2_addr[%0d] got=%h/%0b want=%h/1", i, write_address, write_enable, exp_addr); end
      checks++; if (read_index !== 1'b1) begin failures++; $display("FAIL cap2_ri[%0d] got=%0b want=1", i, read_index); end
    end
    checks++; if (state_dbg !== S_WAIT) begin failures++; $display("FAIL cap2_wait got=%0d want=2", state_dbg); end
    @(negedge clk);
    checks++; if (read_index !== 1'b0) begin failures++; $display("FAIL cap2_flip got=%0b want=0", read_index); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL cap2_rearm got=%0d want=0", state_dbg); end
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL cap2_we_done got=%0b want=0", write_enable); end
    wave_display_idle = 1'b0;
  endtask

  // Sample and idle together in WAIT: flip only, but prev_sign still follows the sample.
  task automatic test_same_cycle();
    logic [8:0] exp_addr;
    send_sample(16'h8000);
    send_sample(16'h0000);
    checks++; if (write_address !== 9'h100 || write_enable !== 1'b1) begin failures++; $display("FAIL same_first got=%h/%0b want=100/1", write_address, write_enable); end
    for (int i = 1; i < 256; i++) begin
      send_sample(16'(i << 8));
      exp_addr = 9'(256 + i);
      checks++; if (write_address !== exp_addr) begin failures++; $display("FAIL same_addr[%0d] got=%h want=%h", i, write_address, exp_addr); end
    end
    @(negedge clk);
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'h0100;
    wave_display_idle = 1'b1;
    @(negedge clk);
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL same_no_write got=%0b want=0", write_enable); end
    checks++; if (read_index !== 1'b1) begin failures++; $display("FAIL same_flip got=%0b want=1", read_index); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL same_state got=%0d want=0", state_dbg); end
    send_sample(16'h0200);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL same_prev_sign got=%0b want=0", write_enable); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp_addr;
    send_sample(16'h8000);
    send_sample(16'h0000);
    checks++; if (write_address !== 9'h000 || write_enable !== 1'b1) begin failures++; $display("FAIL mid_first got=%h/%0b want=000/1", write_address, write_enable); end
    for (int i = 1; i < 100; i++) begin
      send_sample(16'(i << 8));
      exp_addr = 9'(i);
      checks++; if (write_address !== exp_addr) begin failures++; $display("FAIL mid_addr[%0d] got=%h want=%h", i, write_address, exp_addr); end
    end
    checks++; if (write_sample !== 8'hE3) begin failures++; $display("FAIL mid_last_data got=%h want=e3", write_sample); end
    #2 reset = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%0b want=0", write_enable); end
    checks++; if (write_address !== 9'h000) begin failures++; $display("FAIL mid_rst_addr got=%h want=000", write_address); end
    checks++; if (write_sample !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h want=00", write_sample); end
    checks++; if (read_index !== 1'b0) begin failures++; $display("FAIL mid_rst_ri got=%0b want=0", read_index); end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL mid_rst_state got=%0d want=0", state_dbg); end
    @(negedge clk);
    reset = 1'b0;
    send_sample(16'h8000);
    send_sample(16'h0000);
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL mid_restart_we got=%0b want=1", write_enable); end
    checks++; if (write_address !== 9'h100) begin failures++; $display("FAIL mid_restart_addr got=%h want=100", write_address); end
  endtask

  task automatic test_auto_trigger();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_sample(16'h1000);
      checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL auto_quiet[%0d] got=%0b want=0", i, write_enable); end
    end
    send_sample(16'h1000);
`ifdef AUTO_TRIGGER_EN
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL auto_we got=%0b want=1", write_enable); end
    checks++; if (write_address !== 9'h100) begin failures++; $display("FAIL auto_addr got=%h want=100", write_address); end
    checks++; if (write_sample !== 8'h90) begin failures++; $display("FAIL auto_data got=%h want=90", write_sample); end
    checks++; if (state_dbg !== S_ACTIVE) begin failures++; $display("FAIL auto_state got=%0d want=1", state_dbg); end
`else
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL auto_off_we got=%0b want=0", write_enable); end
    for (int i = 0; i < 4; i++) begin
      send_sample(16'h1000);
      checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL auto_off_more[%0d] got=%0b want=0", i, write_enable); end
    end
    checks++; if (state_dbg !== S_ARMED) begin failures++; $display("FAIL auto_off_state got=%0d want=0", state_dbg); end
`endif
  endtask

  initial begin
    test_reset();
    test_no_trigger();
    test_trigger();
    test_capture_fill();
    test_second_capture();
    test_same_cycle();
    test_reset_mid();
    test_auto_trigger();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
